// File: rtl/color_event_tracker_pkg.sv
// Shared definitions for the colour event tracker.
// - Colour codes produced by the upstream colour-detection stage.
// - Debounce FSM state encoding.
// - Event record layout {colour, seq} carried through the event FIFO.
package color_event_tracker_pkg;

  localparam logic [2:0] COLOR_NONE  = 3'b000;
  localparam logic [2:0] COLOR_BLUE  = 3'b001;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_RED   = 3'b100;

  localparam int EVT_W = 7;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] color;
    logic [3:0] seq;
  } evt_t;

  // Only one-hot codes are real colours; 000 and multi-bit codes count as "none".
  function automatic logic is_color(input logic [2:0] c);
    return (c == COLOR_RED) || (c == COLOR_GREEN) || (c == COLOR_BLUE);
  endfunction

endpackage

// File: rtl/color_event_tracker_if.sv
// Event handshake towards the messaging stage.
// - evt_valid : head event present
// - evt_ready : consumer accepts the head event
// - evt_color : colour of the head event
// - evt_seq   : sequence number of the head event
interface color_event_tracker_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_color;
  logic [3:0] evt_seq;

  modport master (output evt_valid, evt_color, evt_seq, input evt_ready);
  modport slave  (input evt_valid, evt_color, evt_seq, output evt_ready);
endinterface

// File: rtl/color_event_tracker_event_fifo.sv
// Synchronous first-word-fall-through FIFO.
// - push/din   : write request and data; a push while full only succeeds
//                if a pop happens in the same cycle
// - pop        : read request, ignored while empty
// - dout       : head entry, zero while empty
// - empty/full : occupancy flags
module event_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk_1MHz,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: storage has no reset; the count gates what is visible, so clearing it buys nothing.
  always_ff @(posedge clk_1MHz) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/color_event_tracker.sv
// Debounces the colour code into discrete "colour block seen" events.
// - clk_1MHz, reset : clock and asynchronous active-high reset
// - color           : colour code from the detection stage, sampled once per period
// - evt             : event FIFO head with valid/ready handshake
// - led_rgb         : {r,g,b} drive, lit with the last event colour for LED_HOLD cycles
// - fifo_overflow   : sticky, set when an event had to be dropped
module color_event_tracker
  import color_event_tracker_pkg::*;
#(
  parameter int SAMPLE_PERIOD  = 12001,
  parameter int STABLE_SAMPLES = 3,
  parameter int CLEAR_SAMPLES  = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int LED_HOLD       = 1000000
) (
  input  logic                   clk_1MHz,
  input  logic                   reset,
  input  logic [2:0]             color,
  color_event_tracker_if.master  evt,
  output logic [2:0]             led_rgb,
  output logic                   fifo_overflow
);

  localparam int TW = $clog2(SAMPLE_PERIOD) + 1;
  localparam int SW = $clog2(STABLE_SAMPLES) + 1;
  localparam int CW = $clog2(CLEAR_SAMPLES) + 1;
  localparam int HW = $clog2(LED_HOLD) + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [SW-1:0] STAB_TGT  = SW'(STABLE_SAMPLES);
  localparam logic [CW-1:0] CLR_TGT   = CW'(CLEAR_SAMPLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(LED_HOLD);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  state_e        state_q;
  logic [2:0]    cand_q;
  logic [SW-1:0] stab_q, stab_inc;
  logic [CW-1:0] clr_q, clr_inc;
  logic [3:0]    seq_q;
  logic          overflow_q;
  logic [2:0]    led_q, led_d;
  logic [HW-1:0] hold_q, hold_d;

  logic tick, sample_valid, emit, pop, accept;
  logic fifo_empty, fifo_full;
  evt_t push_evt, head_evt;

  // Sample tick
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  // NOTE: every clocked register uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  // Event qualification
  assign sample_valid = is_color(color);
  assign stab_inc     = stab_q + 1'b1;
  assign clr_inc      = clr_q + 1'b1;
  assign emit         = tick && (state_q == ST_QUALIFY) && sample_valid &&
                        (color == cand_q) && (stab_inc == STAB_TGT);

  // A full FIFO still accepts the event if the head leaves in the same cycle.
  assign pop    = evt.evt_valid && evt.evt_ready;
  assign accept = emit && (!fifo_full || pop);

  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      state_q <= ST_ARMED;
      cand_q  <= COLOR_NONE;
      stab_q  <= '0;
      clr_q   <= '0;
    end else if (tick) begin
      case (state_q)
        ST_ARMED: begin
          if (sample_valid) begin
            cand_q  <= color;
            stab_q  <= SW'(1);
            state_q <= ST_QUALIFY;
          end
        end
        ST_QUALIFY: begin
          if (!sample_valid) begin
            state_q <= ST_ARMED;
          end else if (color == cand_q) begin
            stab_q <= stab_inc;
            if (stab_inc == STAB_TGT) begin
              clr_q   <= '0;
              state_q <= ST_LOCKED;
            end
          end else begin
            cand_q <= color;
            stab_q <= SW'(1);
          end
        end
        ST_LOCKED: begin
          // Any valid colour breaks the gap; a new block needs CLEAR_SAMPLES consecutive nones.
          if (sample_valid) begin
            clr_q <= '0;
          end else if (clr_inc == CLR_TGT) begin
            clr_q   <= '0;
            state_q <= ST_ARMED;
          end else begin
            clr_q <= clr_inc;
          end
        end
        default: state_q <= ST_ARMED;
      endcase
    end
  end

  // Sequence number and sticky overflow
  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept)              seq_q      <= seq_q + 1'b1;
      else if (emit)           overflow_q <= 1'b1;
    end
  end

  // LED hold timer: dropped events still light the LED.
  // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
  always_comb begin
    led_d  = led_q;
    hold_d = hold_q;
    if (emit) begin
      led_d  = cand_q;
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
      if (hold_q == HW'(1)) led_d = COLOR_NONE;
    end
  end

  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      led_q  <= COLOR_NONE;
      hold_q <= '0;
    end else begin
      led_q  <= led_d;
      hold_q <= hold_d;
    end
  end

  // Event FIFO
  assign push_evt = '{color: cand_q, seq: seq_q};

  event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_1MHz (clk_1MHz),
    .reset    (reset),
    .push     (emit),
    .pop      (pop),
    .din      (push_evt),
    .dout     (head_evt),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_color = head_evt.color;
  assign evt.evt_seq   = head_evt.seq;
  assign led_rgb       = led_q;
  assign fifo_overflow = overflow_q;

endmodule

// File: tb/tb_color_event_tracker.sv
// Directed bench for color_event_tracker with a scoreboard queue: stimulus
// pushes expected events, a monitor pops and compares on each handshake.
module tb_color_event_tracker;
  import color_event_tracker_pkg::*;

  localparam int P = 10;

  logic       clk_1MHz = 1'b0;
  logic       reset    = 1'b1;
  logic [2:0] color    = 3'b000;
  logic [2:0] led_rgb;
  logic       fifo_overflow;

  color_event_tracker_if evt_if ();

  color_event_tracker #(
    .SAMPLE_PERIOD  (P),
    .STABLE_SAMPLES (3),
    .CLEAR_SAMPLES  (2),
    .FIFO_DEPTH     (4),
    .LED_HOLD       (50)
  ) dut (
    .clk_1MHz      (clk_1MHz),
    .reset         (reset),
    .color         (color),
    .evt           (evt_if),
    .led_rgb       (led_rgb),
    .fifo_overflow (fifo_overflow)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  int         checks = 0;
  int         errors = 0;
  evt_t       exp_q[$];
  logic [3:0] exp_seq = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Hold a colour for n sample periods; returns on the negedge after the n-th tick.
  task automatic apply(input logic [2:0] c, input int n);
    color = c;
    repeat (n * P) @(negedge clk_1MHz);
  endtask

  task automatic expect_push(input logic [2:0] c);
    exp_q.push_back('{color: c, seq: exp_seq});
    exp_seq = exp_seq + 4'd1;
  endtask

  task automatic drain(input string name);
    evt_if.evt_ready = 1'b1;
    repeat (8) @(negedge clk_1MHz);
    evt_if.evt_ready = 1'b0;
    check({name, "_valid_low"}, evt_if.evt_valid, 0);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: a handshake seen between negedge and posedge is a pop at that posedge.
  initial begin
    evt_t e;
    forever begin
      @(negedge clk_1MHz);
      #1;
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_evt: got color %0d seq %0d, expected no event",
                   evt_if.evt_color, evt_if.evt_seq);
        end else begin
          e = exp_q.pop_front();
          check("evt_color", evt_if.evt_color, e.color);
          check("evt_seq", evt_if.evt_seq, e.seq);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] cols [6];
    cols[0] = 3'b001; cols[1] = 3'b010; cols[2] = 3'b100;
    cols[3] = 3'b001; cols[4] = 3'b010; cols[5] = 3'b100;
    evt_if.evt_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_1MHz);
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_color", evt_if.evt_color, 0);
    check("rst_seq", evt_if.evt_seq, 0);
    check("rst_led", led_rgb, 0);
    check("rst_ovf", fifo_overflow, 0);
    reset = 1'b0;

    // 1: steady red -> one event one cycle after the third tick, LED holds 50 cycles
    apply(3'b100, 2);
    repeat (P - 1) @(negedge clk_1MHz);
    check("t1_valid_before", evt_if.evt_valid, 0);
    @(negedge clk_1MHz);
    check("t1_valid", evt_if.evt_valid, 1);
    check("t1_color", evt_if.evt_color, 3'b100);
    check("t1_seq", evt_if.evt_seq, 0);
    check("t1_led", led_rgb, 3'b100);
    expect_push(3'b100);
    repeat (49) @(negedge clk_1MHz);
    check("t1_led_still_on", led_rgb, 3'b100);
    @(negedge clk_1MHz);
    check("t1_led_off", led_rgb, 0);
    apply(3'b000, 2);
    drain("t1");

    // 2: candidate restart on colour change
    apply(3'b010, 2);
    apply(3'b001, 1);
    apply(3'b001, 1);
    check("t2_no_evt_early", evt_if.evt_valid, 0);
    apply(3'b001, 1);
    check("t2_evt", evt_if.evt_valid, 1);
    expect_push(3'b001);
    apply(3'b000, 2);
    apply(3'b001, 3);
    expect_push(3'b001);
    apply(3'b000, 2);
    drain("t2");

    // 3: a valid colour inside the gap keeps the tracker locked
    apply(3'b100, 3);
    expect_push(3'b100);
    apply(3'b000, 1);
    apply(3'b100, 1);
    apply(3'b000, 1);
    apply(3'b100, 3);
    drain("t3_locked");
    apply(3'b000, 2);
    apply(3'b100, 3);
    check("t3_rearm_evt", evt_if.evt_valid, 1);
    expect_push(3'b100);
    apply(3'b000, 2);
    drain("t3");

    // 7: multi-bit codes are "none"
    apply(3'b110, 5);
    check("t7_no_evt", evt_if.evt_valid, 0);
    check("t7_led_off", led_rgb, 0);

    // 4: overflow on the 5th and 6th events
    for (int i = 0; i < 6; i++) begin
      apply(cols[i], 3);
      if (i < 4) expect_push(cols[i]);
      check("t4_led_on_emit", led_rgb, cols[i]);
      if (i == 3) check("t4_no_ovf_at_full", fifo_overflow, 0);
      apply(3'b000, 2);
    end
    check("t4_ovf", fifo_overflow, 1);
    drain("t4");
    check("t4_ovf_sticky", fifo_overflow, 1);

    // 6: asynchronous reset mid-QUALIFY with two events queued
    apply(3'b010, 3);
    expect_push(3'b010);
    apply(3'b000, 2);
    apply(3'b001, 3);
    expect_push(3'b001);
    apply(3'b000, 2);
    apply(3'b100, 2);
    check("t6_queued", evt_if.evt_valid, 1);
    check("t6_led_lit", led_rgb, 3'b001);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", evt_if.evt_valid, 0);
    check("t6_rst_led", led_rgb, 0);
    check("t6_rst_ovf", fifo_overflow, 0);
    exp_q.delete();
    exp_seq = 4'd0;
    repeat (2) @(negedge clk_1MHz);
    reset = 1'b0;
    apply(3'b100, 2);
    check("t6_no_evt_2ticks", evt_if.evt_valid, 0);
    apply(3'b100, 1);
    check("t6_evt", evt_if.evt_valid, 1);
    check("t6_seq0", evt_if.evt_seq, 0);
    expect_push(3'b100);

    // 5: push and pop on the same cycle while full
    apply(3'b000, 2);
    apply(3'b010, 3); expect_push(3'b010); apply(3'b000, 2);
    apply(3'b001, 3); expect_push(3'b001); apply(3'b000, 2);
    apply(3'b010, 3); expect_push(3'b010); apply(3'b000, 2);
    apply(3'b100, 2);
    repeat (P - 1) @(negedge clk_1MHz);
    evt_if.evt_ready = 1'b1;
    @(negedge clk_1MHz);
    evt_if.evt_ready = 1'b0;
    expect_push(3'b100);
    check("t5_no_ovf", fifo_overflow, 0);
    check("t5_valid", evt_if.evt_valid, 1);
    apply(3'b000, 2);
    drain("t5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
